// File: rtl/sgf_norm_round_pkg.sv
// sgf_norm_round_pkg: FSM state encoding and significand/exponent widths for the
// single and double precision multiplier paths.
package sgf_norm_round_pkg;
    localparam int SGL_SW = 24;
    localparam int SGL_EW = 8;
    localparam int DBL_SW = 53;
    localparam int DBL_EW = 11;
    typedef enum logic [2:0] {IDLE, NORM, ROUND, ADJ, DONE} state_t;
endpackage

// File: rtl/RegisterAdd.sv
// RegisterAdd: load-enabled capture register with synchronous active-high reset.
module RegisterAdd #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) q <= rst ? '0 : load ? d : q;
endmodule

// File: rtl/sgf_norm_round.sv
// sgf_norm_round: normalizes the 2*SW-bit significand product, rounds to nearest
// even and clamps the exponent to overflow/underflow/zero results.
module sgf_norm_round
    import sgf_norm_round_pkg::*;
#(
    parameter int SW = SGL_SW,
    parameter int EW = SGL_EW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [2*SW-1:0] sgf_product_i,
    input  logic [EW+1:0]   exp_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [SW-2:0]   sgf_o,
    output logic [EW-1:0]   exp_o,
    output logic            overflow_o,
    output logic            underflow_o
);
    localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'(2**EW - 1);
    localparam logic signed [EW+1:0] EXP_ONE = (EW+2)'(1);
    state_t                 state, next_state;
    logic [2*SW+EW+1:0]     cap_q;
    logic [2*SW-1:0]        p;
    logic signed [EW+1:0]   e;
    logic [SW-1:0]          sig_r;
    logic                   g_r, s_r;
    logic signed [EW+1:0]   exp_r;
    logic                   inc, accept, fin, zero, ovf, unf;
    logic [SW:0]            sum;
    logic [SW-1:0]          fin_sig;
    logic signed [EW+1:0]   fin_exp;
    assign accept = load_i & ready_o;
    RegisterAdd #(.W(2*SW+EW+2)) u_cap (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .d    ({sgf_product_i, exp_i}),
        .q    (cap_q)
    );
    assign {p, e} = cap_q;
    assign inc = g_r & (s_r | sig_r[0]);
    assign sum = {1'b0, sig_r} + (SW+1)'(inc);
    always_ff @(posedge clk) state <= rst ? IDLE : next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = load_i ? NORM : state;
            NORM:       next_state = ROUND;
            ROUND:      next_state = sum[SW] ? ADJ : DONE;
            ADJ:        next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end
    always_comb begin
        ready_o = state == IDLE || state == DONE;
        done_o  = state == DONE;
        fin     = (state == ROUND && !sum[SW]) || state == ADJ;
    end
    // A rounding carry leaves the significand at exactly 1.000..0, one binade up.
    always_comb begin
        fin_sig = state == ADJ ? {1'b1, {(SW-1){1'b0}}} : sum[SW-1:0];
        fin_exp = state == ADJ ? exp_r + EXP_ONE : exp_r;
        zero    = fin_sig == '0;
        ovf     = !zero && fin_exp >= EXP_MAX;
        unf     = !zero && !ovf && (fin_exp[EW+1] || fin_exp == '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r       <= '0;
            g_r         <= 1'b0;
            s_r         <= 1'b0;
            exp_r       <= '0;
            sgf_o       <= '0;
            exp_o       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (state == NORM) begin
                sig_r <= p[2*SW-1] ? p[2*SW-1:SW] : p[2*SW-2:SW-1];
                g_r   <= p[2*SW-1] ? p[SW-1] : p[SW-2];
                s_r   <= p[2*SW-1] ? |p[SW-2:0] : |p[SW-3:0];
                exp_r <= p[2*SW-1] ? e + EXP_ONE : e;
            end
            if (accept) begin
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
            end
            if (fin) begin
                overflow_o  <= ovf;
                underflow_o <= unf;
                sgf_o       <= (zero || ovf || unf) ? '0 : fin_sig[SW-2:0];
                exp_o       <= (zero || unf) ? '0 : ovf ? '1 : fin_exp[EW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_sgf_norm_round.sv
// tb_sgf_norm_round: directed and random products against an arithmetic
// round-to-nearest-even reference.
module tb_sgf_norm_round;
    logic        clk, rst, load_i;
    logic [47:0] sgf_product_i;
    logic [9:0]  exp_i;
    logic        ready_o, done_o, overflow_o, underflow_o;
    logic [22:0] sgf_o;
    logic [7:0]  exp_o;
    int          checks, failures;
    logic [22:0] m_sgf;
    logic [7:0]  m_exp;
    logic        m_ov, m_un;

    sgf_norm_round #(.SW(24), .EW(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_i),
        .sgf_product_i (sgf_product_i),
        .exp_i         (exp_i),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .sgf_o         (sgf_o),
        .exp_o         (exp_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: plain, 1: extra load pulse while in NORM, 2: reset while in ROUND
    task automatic run(input logic [47:0] p, input int e, input int mode);
        longint sig, rem, half, unit;
        int     ex, lat;
        bit     top;
        top  = p >= 48'h800000000000;
        unit = top ? 64'd16777216 : 64'd8388608;
        half = unit / 2;
        sig  = longint'(p) / unit;
        rem  = longint'(p) % unit;
        ex   = e + (top ? 1 : 0);
        lat  = 3;
        if (rem > half || (rem == half && sig % 2 == 1)) sig++;
        if (sig == 64'd16777216) begin
            sig = 64'd8388608;
            ex++;
            lat = 4;
        end
        m_ov = 0;
        m_un = 0;
        if (sig == 0) begin
            m_sgf = '0;
            m_exp = '0;
        end else if (ex >= 255) begin
            m_ov  = 1;
            m_sgf = '0;
            m_exp = 8'hFF;
        end else if (ex <= 0) begin
            m_un  = 1;
            m_sgf = '0;
            m_exp = '0;
        end else begin
            m_sgf = 23'(sig % 64'd8388608);
            m_exp = 8'(ex);
        end
        @(negedge clk);
        chk("ready_before_load", ready_o, 1);
        sgf_product_i = p;
        exp_i         = 10'(e);
        load_i        = 1;
        @(negedge clk);
        load_i = 0;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("done_k%0d", k), done_o, (k == lat - 1) ? 1 : 0);
            if (mode == 1 && k == 0) begin
                sgf_product_i = ~p;
                exp_i         = 10'(e + 3);
                load_i        = 1;
            end
            if (mode == 1 && k == 1) load_i = 0;
            if (mode == 2 && k == 1) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                chk("rst_done", done_o, 0);
                chk("rst_ready", ready_o, 1);
                chk("rst_sgf", sgf_o, 0);
                chk("rst_exp", exp_o, 0);
                chk("rst_ovf", overflow_o, 0);
                chk("rst_unf", underflow_o, 0);
                return;
            end
        end
        chk("sgf", sgf_o, m_sgf);
        chk("exp", exp_o, m_exp);
        chk("ovf", overflow_o, m_ov);
        chk("unf", underflow_o, m_un);
    endtask

    initial begin
        longint a, b;
        clk           = 0;
        rst           = 1;
        load_i        = 0;
        sgf_product_i = '0;
        exp_i         = '0;
        checks        = 0;
        failures      = 0;
        repeat (2) @(negedge clk);
        chk("reset_done", done_o, 0);
        chk("reset_ready", ready_o, 1);
        chk("reset_sgf", sgf_o, 0);
        chk("reset_exp", exp_o, 0);
        chk("reset_flags", {overflow_o, underflow_o}, 0);
        rst = 0;
        run(48'h400000000000, 127, 0);
        run(48'h800000000000, 127, 0);
        run({24'h800001, 1'b1, 22'b0}, 127, 0);
        run({24'h800000, 1'b1, 22'b0}, 127, 0);
        run({24'hFFFFFF, 1'b1, 22'b0}, 100, 0);
        run(48'h800000000000, 254, 0);
        run(48'h400000000000, 0, 0);
        run(48'h0, 127, 0);
        run(48'hC00000800000, 90, 1);
        run(48'h5A5A5A5A5A5A, 60, 0);
        repeat (3) @(negedge clk);
        chk("hold_done", done_o, 1);
        chk("hold_sgf", sgf_o, m_sgf);
        chk("hold_exp", exp_o, m_exp);
        for (int i = 0; i < 30; i++) begin
            a = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            b = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            run(48'(a * b), int'($urandom_range(350, 0)) - 50, 0);
        end
        run(48'h9000000000FF, 120, 2);
        run(48'h600000000001, 10, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
